// File: rtl/draw_pkg.sv
// draw_pkg
//   Shared definitions for the framebuffer drawing blocks: the redraw
//   scheduler state encoding, screen geometry and default pixel widths.
package draw_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ERASE = 4'd1,
    MAP   = 4'd2,
    DRAW  = 4'd3,
    FIN   = 4'd4
  } sched_state_t;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;

endpackage

// File: rtl/plot_port_mux.sv
// plot_port_mux
//   Registered 2:1 pixel mux in front of the VGA adapter plot port.
//   Ports:
//     clock, reset            clock and asynchronous active-high reset
//     selMap / selSpr         pass map stream / sprite stream (selMap wins)
//     map*, spr*              engine pixel streams (x, y, colour, plot)
//     x, y, colour, plot      registered plot port, one cycle behind inputs
//   With neither select, plot is blanked and x/y/colour hold their values.
module plot_port_mux #(
  parameter int X_W      = draw_pkg::X_W,
  parameter int Y_W      = draw_pkg::Y_W,
  parameter int COLOUR_W = draw_pkg::COLOUR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                selMap,
  input  logic                selSpr,
  input  logic [X_W-1:0]      mapX,
  input  logic [Y_W-1:0]      mapY,
  input  logic [COLOUR_W-1:0] mapColour,
  input  logic                mapPlot,
  input  logic [X_W-1:0]      sprPixX,
  input  logic [Y_W-1:0]      sprPixY,
  input  logic [COLOUR_W-1:0] sprColour,
  input  logic                sprPlot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (selMap) begin
      x      <= mapX;
      y      <= mapY;
      colour <= mapColour;
      plot   <= mapPlot;
    end else if (selSpr) begin
      x      <= sprPixX;
      y      <= sprPixY;
      colour <= sprColour;
      plot   <= sprPlot;
    end else begin
      plot   <= 1'b0;
    end
  end

endmodule

// File: rtl/redraw_scheduler.sv
// redraw_scheduler
//   Sequences framebuffer writes from the map and sprite engines onto the
//   single VGA plot port.
//   Ports:
//     clock, reset                  clock, asynchronous active-high reset
//     gameState, frameTick          triggers (state change = full redraw,
//                                   tick with moved sprite = move only)
//     charX, charY                  current sprite position
//     mapStart/mapLayer/mapDone     map engine job control
//     map*                          map engine pixel stream
//     sprStart/sprErase/sprX/sprY/sprDone   sprite engine job control
//     spr*                          sprite engine pixel stream
//     x, y, colour, plot            VGA adapter plot port (registered)
//     doneRedraw                    pulse when a full redraw completes
//     busy, timeoutErr, dbgState    status; dbgState is the FSM state
//   Engine handshake: the scheduler raises *Start for exactly the first cycle
//   of a job state with the job parameters already stable; the engine answers
//   with a one-cycle *Done pulse, and the scheduler leaves the job state on
//   the clock edge that samples it. Done pulses outside the owning state are
//   ignored. A job that never answers is abandoned after TIMEOUT cycles.
module redraw_scheduler
  import draw_pkg::*;
#(
  parameter int X_W      = draw_pkg::X_W,
  parameter int Y_W      = draw_pkg::Y_W,
  parameter int COLOUR_W = draw_pkg::COLOUR_W,
  parameter int TIMEOUT  = 131072
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          gameState,
  input  logic                frameTick,
  input  logic [X_W-1:0]      charX,
  input  logic [Y_W-1:0]      charY,
  output logic                mapStart,
  output logic [3:0]          mapLayer,
  input  logic                mapDone,
  input  logic [X_W-1:0]      mapX,
  input  logic [Y_W-1:0]      mapY,
  input  logic [COLOUR_W-1:0] mapColour,
  input  logic                mapPlot,
  output logic                sprStart,
  output logic                sprErase,
  output logic [X_W-1:0]      sprX,
  output logic [Y_W-1:0]      sprY,
  input  logic                sprDone,
  input  logic [X_W-1:0]      sprPixX,
  input  logic [Y_W-1:0]      sprPixY,
  input  logic [COLOUR_W-1:0] sprColour,
  input  logic                sprPlot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                doneRedraw,
  output logic                busy,
  output logic                timeoutErr,
  output logic [3:0]          dbgState
);

  localparam logic [17:0] TMO_LAST = 18'(TIMEOUT - 1);

  sched_state_t   state;
  logic [3:0]     lastState;
  logic [X_W-1:0] oldX;
  logic [Y_W-1:0] oldY;
  logic           pendFull;
  logic           isFull;     // current sequence is a full redraw
  logic [17:0]    cnt;

  logic fullTrig, moved, jobDone, tmo;

  assign fullTrig = (gameState != lastState);
  assign moved    = (charX != oldX) || (charY != oldY);
  assign tmo      = (cnt == TMO_LAST);
  assign busy     = (state != IDLE);
  assign dbgState = state;

  // Only the engine that owns the current state may end its job.
  always_comb begin
    jobDone = 1'b0;
    case (state)
      ERASE, DRAW: jobDone = sprDone;
      MAP:         jobDone = mapDone;
      default:     jobDone = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lastState  <= '0;
      oldX       <= '0;
      oldY       <= '0;
      pendFull   <= 1'b0;
      isFull     <= 1'b0;
      cnt        <= '0;
      mapStart   <= 1'b0;
      mapLayer   <= '0;
      sprStart   <= 1'b0;
      sprErase   <= 1'b0;
      sprX       <= '0;
      sprY       <= '0;
      doneRedraw <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      mapStart   <= 1'b0;
      sprStart   <= 1'b0;
      doneRedraw <= 1'b0;
      cnt        <= cnt + 18'd1;
      if (fullTrig) lastState <= gameState;

      case (state)
        IDLE: begin
          // Full redraw has priority; a simultaneous tick is absorbed.
          if (fullTrig || (frameTick && moved)) begin
            state    <= ERASE;
            isFull   <= fullTrig;
            if (fullTrig) mapLayer <= gameState;
            sprStart <= 1'b1;
            sprErase <= 1'b1;
            sprX     <= oldX;
            sprY     <= oldY;
            cnt      <= '0;
          end
        end

        ERASE, MAP: begin
          if (fullTrig) pendFull <= 1'b1;
          if (jobDone || tmo) begin
            if (!jobDone) timeoutErr <= 1'b1;
            if (state == ERASE && isFull) begin
              state    <= MAP;
              mapStart <= 1'b1;
              cnt      <= '0;
            end else begin
              state    <= DRAW;
              sprStart <= 1'b1;
              sprErase <= 1'b0;
              sprX     <= charX;
              sprY     <= charY;
              oldX     <= charX;
              oldY     <= charY;
              cnt      <= '0;
            end
          end
        end

        DRAW: begin
          if (fullTrig) pendFull <= 1'b1;
          if (jobDone || tmo) begin
            if (!jobDone) timeoutErr <= 1'b1;
            state      <= FIN;
            // A change arriving on this edge also forces a follow-up redraw.
            doneRedraw <= isFull && !pendFull && !fullTrig;
          end
        end

        FIN: begin
          if (pendFull || fullTrig) begin
            state    <= ERASE;
            isFull   <= 1'b1;
            pendFull <= 1'b0;
            mapLayer <= fullTrig ? gameState : lastState;
            sprStart <= 1'b1;
            sprErase <= 1'b1;
            sprX     <= oldX;
            sprY     <= oldY;
            cnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  plot_port_mux #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOUR_W (COLOUR_W)
  ) u_mux (
    .clock     (clock),
    .reset     (reset),
    .selMap    (state == MAP),
    .selSpr    ((state == ERASE) || (state == DRAW)),
    .mapX      (mapX),
    .mapY      (mapY),
    .mapColour (mapColour),
    .mapPlot   (mapPlot),
    .sprPixX   (sprPixX),
    .sprPixY   (sprPixY),
    .sprColour (sprColour),
    .sprPlot   (sprPlot),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

endmodule
